// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and arbiter FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at/after ptr, wrapping.
module rr_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx,
    output logic               any
);

    int unsigned     k;
    logic [IDW-1:0]  kidx;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        kidx  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = 32'(ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            kidx = IDW'(k);
            if (!any && req[kidx]) begin
                grant[kidx] = 1'b1;
                idx         = kidx;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU, one op in flight, held response.
// Optional feature: define ALU_OVF_STICKY_EN to enable the sticky overflow flag.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned WIDTH   = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_src1,
    input  logic [NUM_REQ*WIDTH-1:0]   req_src2,
    input  logic [NUM_REQ*4-1:0]       req_code,
    output logic [WIDTH-1:0]           alu_source_1,
    output logic [WIDTH-1:0]           alu_source_2,
    output logic [3:0]                 alu_code,
    input  logic [WIDTH-1:0]           alu_result,
    input  logic                       alu_overflow,
    input  logic                       alu_zero,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_result,
    output logic                       rsp_overflow,
    output logic                       rsp_zero,
    output logic                       ovf_sticky,
    input  logic                       ovf_clear
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    state_t               state, state_nxt;
    logic [IDW-1:0]       rr_ptr;
    logic [NUM_REQ-1:0]   grant;
    logic [IDW-1:0]       grant_idx;
    logic                 grant_any;
    logic [WIDTH-1:0]     sel_src1, sel_src2;
    logic [3:0]           sel_code;
    logic                 rsp_fire;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    always_comb begin
        sel_src1 = '0;
        sel_src2 = '0;
        sel_code = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_src1 = req_src1[i*WIDTH +: WIDTH];
                sel_src2 = req_src2[i*WIDTH +: WIDTH];
                sel_code = req_code[i*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant is gated by rst so nothing is accepted while reset is held.
    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE) req_ready = grant;
        rsp_valid = (state == RESP);
    end

    assign rsp_fire = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_source_1 <= '0;
            alu_source_2 <= '0;
            alu_code     <= '0;
            rsp_id       <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rr_ptr       <= '0;
        end else begin
            if (state == IDLE && grant_any) begin
                alu_source_1 <= sel_src1;
                alu_source_2 <= sel_src2;
                alu_code     <= sel_code;
                rsp_id       <= grant_idx;
            end
            if (state == EXEC) begin
                rsp_result   <= alu_result;
                rsp_overflow <= alu_overflow;
                rsp_zero     <= alu_zero;
            end
            if (rsp_fire) begin
                rr_ptr <= (rsp_id == IDW'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
            end
        end
    end

`ifdef ALU_OVF_STICKY_EN
    always_ff @(posedge clk) begin
        if (rst)                            ovf_sticky <= 1'b0;
        else if (rsp_fire && rsp_overflow)  ovf_sticky <= 1'b1;
        else if (ovf_clear)                 ovf_sticky <= 1'b0;
    end
`else
    logic unused_ovf_clear;
    assign unused_ovf_clear = ovf_clear;
    assign ovf_sticky       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural 64-bit ALU model.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned W  = 64;

`ifdef ALU_OVF_STICKY_EN
    localparam logic STICKY_EXP = 1'b1;
`else
    localparam logic STICKY_EXP = 1'b0;
`endif

    logic            clk, rst;
    logic [NR-1:0]   req_valid, req_ready;
    logic [NR*W-1:0] req_src1, req_src2;
    logic [NR*4-1:0] req_code;
    logic [W-1:0]    alu_source_1, alu_source_2, alu_result, rsp_result;
    logic [3:0]      alu_code;
    logic            alu_overflow, alu_zero;
    logic            rsp_valid, rsp_ready, rsp_overflow, rsp_zero;
    logic [0:0]      rsp_id;
    logic            ovf_sticky, ovf_clear;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    alu_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_src1     (req_src1),
        .req_src2     (req_src2),
        .req_code     (req_code),
        .alu_source_1 (alu_source_1),
        .alu_source_2 (alu_source_2),
        .alu_code     (alu_code),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .ovf_sticky   (ovf_sticky),
        .ovf_clear    (ovf_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU model
    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_code)
            ALU_AND: alu_result = alu_source_1 & alu_source_2;
            ALU_OR:  alu_result = alu_source_1 | alu_source_2;
            ALU_ADD: begin
                alu_result   = alu_source_1 + alu_source_2;
                alu_overflow = (alu_source_1[W-1] == alu_source_2[W-1]) &&
                               (alu_result[W-1] != alu_source_1[W-1]);
            end
            ALU_SUB: begin
                alu_result   = alu_source_1 - alu_source_2;
                alu_overflow = (alu_source_1[W-1] != alu_source_2[W-1]) &&
                               (alu_result[W-1] != alu_source_1[W-1]);
            end
            default: ;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int unsigned r, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] c);
        req_src1[r*W +: W] = a;
        req_src2[r*W +: W] = b;
        req_code[r*4 +: 4] = c;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_src1 = '0; req_src2 = '0; req_code = '0;
        rsp_ready = 1'b0; ovf_clear = 1'b0;

        // 1: reset
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_alu_src1", alu_source_1, 0);
        check("rst_alu_code", alu_code, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_ovf_sticky", ovf_sticky, 0);
        @(negedge clk); #1;
        check("idle_no_grant", req_ready, 0);
        @(negedge clk);

        // 2: req0 ADD 5+7
        set_op(0, 64'd5, 64'd7, ALU_ADD); req_valid = 2'b01;
        #1 check("t2_accept", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00; set_op(0, '1, '1, ALU_SUB);
        #1;
        check("t2_exec_ready", req_ready, 0);
        check("t2_alu_src1", alu_source_1, 5);
        check("t2_alu_src2", alu_source_2, 7);
        check("t2_alu_code", alu_code, ALU_ADD);
        check("t2_exec_rsp_valid", rsp_valid, 0);
        @(negedge clk); #1;
        check("t2_rsp_valid", rsp_valid, 1);
        check("t2_rsp_result", rsp_result, 12);
        check("t2_rsp_id", rsp_id, 0);
        check("t2_rsp_zero", rsp_zero, 0);
        check("t2_rsp_ovf", rsp_overflow, 0);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("t2_rsp_done", rsp_valid, 0);
        @(negedge clk);

        // 3: both requesters continuously valid, fresh pointer
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_op(0, 64'hF0, 64'h0F, ALU_OR);
        set_op(1, 64'hFF, 64'h0F, ALU_AND);
        req_valid = 2'b11;
        begin
            int unsigned ng, nr, cyc, last_cyc;
            logic [0:0]  last_g;
            ng = 0; nr = 0; cyc = 0; last_cyc = 0; last_g = 1'b0;
            while ((ng < 4 || nr < 4) && cyc < 40) begin
                #1;
                cyc++;
                if (req_ready != 0) begin
                    check("rr_grant", req_ready, (ng % 2 == 0) ? 2'b01 : 2'b10);
                    if (ng > 0) check("rr_spacing", cyc - last_cyc, 3);
                    last_cyc = cyc;
                    last_g   = req_ready[1];
                    ng++;
                end
                if (rsp_valid) begin
                    check("rr_rsp_id", rsp_id, last_g);
                    check("rr_rsp_result", rsp_result, last_g ? 64'h0F : 64'hFF);
                    nr++;
                end
                @(negedge clk);
            end
            if (ng < 4 || nr < 4) check("rr_timeout", ng + nr, 8);
        end
        req_valid = 2'b00;

        // 4: req1 signed overflow on SUB
        set_op(1, 64'h8000_0000_0000_0000, 64'd1, ALU_SUB);
        req_valid = 2'b10; rsp_ready = 1'b0;
        #1 check("t4_accept", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk); #1;
        check("t4_rsp_valid", rsp_valid, 1);
        check("t4_rsp_ovf", rsp_overflow, 1);
        check("t4_rsp_result", rsp_result, 64'h7FFF_FFFF_FFFF_FFFF);
        check("t4_rsp_id", rsp_id, 1);
        check("t4_sticky_before", ovf_sticky, 0);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("t4_sticky_set", ovf_sticky, STICKY_EXP);
        @(negedge clk); #1;
        check("t4_sticky_hold", ovf_sticky, STICKY_EXP);
        ovf_clear = 1'b1;
        @(negedge clk); #1;
        check("t4_sticky_clear", ovf_sticky, 0);
        ovf_clear = 1'b0;
        @(negedge clk);

        // 5: unchecked code 9 on req0, response stalled 5 cycles
        set_op(0, 64'd3, 64'd3, 4'd9);
        req_valid = 2'b01; rsp_ready = 1'b0;
        #1 check("t5_accept", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b11;
        #1 check("t5_alu_code", alu_code, 4'd9);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t5_stall_valid", rsp_valid, 1);
            check("t5_stall_result", rsp_result, 0);
            check("t5_stall_zero", rsp_zero, 1);
            check("t5_stall_ovf", rsp_overflow, 0);
            check("t5_stall_id", rsp_id, 0);
            check("t5_stall_no_grant", req_ready, 0);
            if (i == 4) rsp_ready = 1'b1;
            @(negedge clk);
        end
        #1 check("t5_next_grant", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk); @(negedge clk);

        // 6: reset while req1's op is in EXEC; pointer was 1 before
        set_op(0, 64'd1, 64'd1, ALU_ADD);
        req_valid = 2'b01;
        #1 check("t6_pre_accept", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk); @(negedge clk);
        set_op(1, 64'd9, 64'd4, ALU_SUB);
        req_valid = 2'b10;
        #1 check("t6_accept", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b00; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_alu_src1_cleared", alu_source_1, 0);
        for (int i = 0; i < 3; i++) begin
            check("t6_no_rsp", rsp_valid, 0);
            @(negedge clk); #1;
        end
        @(negedge clk);
        req_valid = 2'b11;
        #1 check("t6_ptr_reset_grant", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk); @(negedge clk); @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
